// File: rtl/xnor_reduce_scheduler_if.sv
// Requester/consumer handshake bundle for the shared serial XNOR reducer.
// The slave modport is the scheduler's view; master is the requester/consumer side.
interface xnor_reduce_scheduler_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_data;
    logic [IDW-1:0]        resp_id;
    logic                  resp_ready;

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/xnor_reduce_scheduler.sv
// Round-robin scheduler sharing one bit-serial XNOR-reduction cell among NREQ requesters.
// Words are reduced LSB first with the accumulator seeded to 1.
module xnor_reduce_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    xnor_reduce_scheduler_if.slave  bus,
    output logic                    busy
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic             res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;
    logic [NREQ-1:0]  ready;

    // Scan starts just after the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = IDW'((32'(last_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        last_d     = last_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        ready      = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    ready[grant_idx] = 1'b1;
                    sh_d    = bus.req_data[32'(grant_idx)*WIDTH +: WIDTH];
                    acc_d   = 1'b1;
                    cnt_d   = '0;
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = StShift;
                end
            end
            StShift: begin
                acc_d = ~(acc_q ^ sh_q[0]);
                sh_d  = sh_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Result registers only move here so they hold between jobs.
                    res_data_d = acc_d;
                    res_id_d   = id_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (RESET) begin
            ready = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            id_q       <= '0;
            last_q     <= IDW'(NREQ - 1);
            res_data_q <= 1'b0;
            res_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            last_q     <= last_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = (state_q == StDone);
    assign bus.resp_data  = res_data_q;
    assign bus.resp_id    = res_id_q;
    assign busy           = (state_q != StIdle);
endmodule

// File: tb/tb_xnor_reduce_scheduler.sv
// Scoreboard bench for xnor_reduce_scheduler: directed words, expected grants and results
// queued at issue time and checked by an independent negedge monitor.
module tb_xnor_reduce_scheduler;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   exp_grant[$];
    int   exp_id[$];
    int   exp_data[$];
    int   gcyc[$];
    int   last_gcyc = 0;
    int   ready2_cnt = 0;
    logic prev_valid = 1'b0;
    int   mon_g;

    logic [7:0] t2_word [5] = '{8'h01, 8'h07, 8'hFF, 8'h03, 8'h80};
    int         t2_exp  [5] = '{0, 0, 1, 1, 0};

    xnor_reduce_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    xnor_reduce_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] gm;
        @(negedge clk);
        gm = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~gm;
    endtask

    task automatic set_req(input int i, input logic [7:0] w);
        bus.req_data[i*WIDTH +: WIDTH] = w;
        bus.req_valid[i] = 1'b1;
    endtask

    task automatic push_resp(input int id, input int d);
        exp_id.push_back(id);
        exp_data.push_back(d);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy && bus.req_valid == '0) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got timeout expected idle (cycle %0d)", cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_valid", int'(bus.resp_valid), 0);
        chk("rst_resp_data", int'(bus.resp_data), 0);
        chk("rst_resp_id", int'(bus.resp_id), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        rst = 1'b0;
        tick();
    endtask

    // Monitor: grants, results and first-result latency.
    always @(negedge clk) begin
        if (|bus.req_ready) begin
            chk("grant_onehot", int'($onehot(bus.req_ready)), 1);
            if (exp_grant.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got %b expected none", bus.req_ready);
            end else begin
                mon_g = exp_grant.pop_front();
                chk("grant", int'(bus.req_ready), 1 << mon_g);
            end
            gcyc.push_back(cyc);
            last_gcyc = cyc;
            if (bus.req_ready[2]) ready2_cnt++;
        end
        if (busy) chk("ready_while_busy", int'(bus.req_ready), 0);
        if (bus.resp_valid && !prev_valid) chk("latency", cyc - last_gcyc, WIDTH + 1);
        prev_valid = bus.resp_valid;
        if (bus.resp_valid && bus.resp_ready && !rst) begin
            if (exp_id.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id %0d data %0d expected none",
                         bus.resp_id, bus.resp_data);
            end else begin
                chk("resp_id", int'(bus.resp_id), exp_id.pop_front());
                chk("resp_data", int'(bus.resp_data), exp_data.pop_front());
            end
        end
    end

    initial begin
        int p;
        int r2;
        bit seen;
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        do_reset();

        // Single word 0x00 from req0: grant now, result at +9, idle by +11.
        set_req(0, 8'h00);
        exp_grant.push_back(0);
        push_resp(0, 1);
        repeat (11) tick();
        chk("t1_busy_t11", int'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            set_req(1, t2_word[i]);
            exp_grant.push_back(1);
            push_resp(1, t2_exp[i]);
            wait_idle();
        end

        // All four held together: 0,1,2,3 ten cycles apart.
        do_reset();
        gcyc.delete();
        set_req(0, 8'h0F); set_req(1, 8'h10); set_req(2, 8'hAA); set_req(3, 8'h15);
        exp_grant.push_back(0); exp_grant.push_back(1);
        exp_grant.push_back(2); exp_grant.push_back(3);
        push_resp(0, 1); push_resp(1, 0); push_resp(2, 1); push_resp(3, 0);
        wait_idle();
        chk("t3_grant_count", gcyc.size(), 4);
        if (gcyc.size() == 4) begin
            for (int k = 1; k < 4; k++) chk("t3_spacing", gcyc[k] - gcyc[k-1], 10);
        end
        set_req(0, 8'h01); set_req(2, 8'h03);
        exp_grant.push_back(0); exp_grant.push_back(2);
        push_resp(0, 0); push_resp(2, 1);
        wait_idle();

        // Backpressure with req0 pending.
        gcyc.delete();
        bus.resp_ready = 1'b0;
        set_req(3, 8'h33);
        exp_grant.push_back(3);
        push_resp(3, 1);
        tick();
        set_req(0, 8'h0F);
        exp_grant.push_back(0);
        push_resp(0, 1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk("t4_valid_seen", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", int'(bus.resp_valid), 1);
            chk("t4_hold_data", int'(bus.resp_data), 1);
            chk("t4_hold_id", int'(bus.resp_id), 3);
            chk("t4_no_ready", int'(bus.req_ready), 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        p = cyc;
        tick();
        wait_idle();
        chk("t4_grant_count", gcyc.size(), 2);
        if (gcyc.size() == 2) chk("t4_accept_after_pulse", gcyc[1], p + 1);

        // Reset mid-shift (cnt==3): job discarded, req0 wins afterwards.
        set_req(0, 8'h55);
        exp_grant.push_back(0);
        repeat (4) tick();
        chk("t5_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy_after", int'(busy), 0);
        chk("t5_valid_after", int'(bus.resp_valid), 0);
        set_req(1, 8'h01); set_req(0, 8'h7F);
        exp_grant.push_back(0); exp_grant.push_back(1);
        push_resp(0, 0); push_resp(1, 0);
        wait_idle();

        // req2 drops before its turn; req3 takes it.
        r2 = ready2_cnt;
        set_req(1, 8'h00);
        exp_grant.push_back(1);
        push_resp(1, 1);
        tick();
        set_req(2, 8'h5A);
        tick();
        tick();
        set_req(3, 8'hC3);
        tick();
        bus.req_valid[2] = 1'b0;
        exp_grant.push_back(3);
        push_resp(3, 1);
        wait_idle();
        chk("t6_no_req2_grant", ready2_cnt - r2, 0);

        repeat (3) tick();
        chk("grants_left", exp_grant.size(), 0);
        chk("resps_left", exp_id.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/xnor_reduce_scheduler.md
Name: xnor_reduce_scheduler

Overview:
- Shares one bit-serial XNOR-reduction stage among NREQ requesters; each requester submits a WIDTH-bit word.
- Round-robin arbitration; the granted word is fed through the single XNOR cell one bit per cycle, LSB first, with the accumulator seeded to 1. This is the serial, time-multiplexed form of the LUT-chain XNOR reducer.
- Sits between requester ports and a single result consumer, using valid/ready on both sides.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, bits per word and serial steps per job (1..32).
- IDW, clog2(NREQ), width of resp_id; derived, not overridable.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i set: requester i has a word pending.
- req_data  in  NREQ*WIDTH  word of requester i in bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept strobe.
- resp_valid  out  1  result available.
- resp_data  out  1  reduction result.
- resp_id  out  IDW  index of the requester that owns the result.
- resp_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: sh[WIDTH], acc, cnt (clog2(WIDTH+1) bits), id, last.
- Reset (sync, any state) forces:
  - state=IDLE; resp_valid=0; resp_data=0; resp_id=0; busy=0.
  - req_ready=0; last=NREQ-1, so requester 0 wins first.
  - any in-flight job is discarded.
- IDLE, arbitration and accept:
  - If any req_valid is set, grant g = first set bit scanning (last+1)..(last+NREQ) mod NREQ.
  - req_ready[g]=1 combinationally in this cycle only; the handshake completes in this cycle.
  - On the edge: sh<=req_data[g]; acc<=1; cnt<=0; id<=g; last<=g; state<=SHIFT.
  - If no req_valid is set: req_ready=0 and the block stays in IDLE.
- req_ready rules:
  - req_ready is 0 in SHIFT and DONE.
  - Never more than one bit of req_ready is set.
  - Requesters hold req_valid and req_data stable until they see their req_ready.
  - A requester may drop req_valid at any time before grant; such a requester is simply skipped.
- SHIFT, one step per cycle:
  - acc<=~(acc^sh[0]); sh<=sh>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1, after that step state<=DONE.
- Result: final acc = 1 ^ (^word) ^ (WIDTH mod 2). For even WIDTH this equals ~^word.
- DONE:
  - resp_valid=1; resp_data=acc; resp_id=id. These hold stable until the cycle with resp_ready=1.
  - On that edge state<=IDLE and resp_valid<=0.
- Latency:
  - Word accepted in cycle t → resp_valid first high in cycle t+WIDTH+1.
  - Minimum spacing between accepts is WIDTH+2 cycles (IDLE, WIDTH×SHIFT, DONE).
- resp_ready while not DONE is ignored.
- Backpressure: DONE may last indefinitely; no new request is accepted meanwhile.
- Simultaneous RESET and a handshake (either side): reset wins; the handshake is void and req_ready is forced 0 in that cycle.
- resp_data and resp_id outside DONE: hold their last values (0 after reset). The consumer qualifies them only with resp_valid.

Test Plan:
- Req0 only, word 0x00, resp_ready=1 (accept cycle t) → req_ready=4'b0001 in t; resp_valid high exactly at t+9 with resp_data=1, resp_id=0; busy low at t+11.
- Sequential single words from req1: 0x01→0, 0x07→0, 0xFF→1, 0x03→1, 0x80→0; each with resp_id=1.
- All four requesters valid together and held:
  - grant order 0,1,2,3, each accept 10 cycles apart;
  - then req0 and req2 re-request → order 0 then 2.
- Backpressure: resp_ready=0 for 5 cycles in DONE → resp_valid, resp_data and resp_id stable; req_ready stays 0 despite pending req_valid; accept occurs the cycle after resp_ready pulses.
- RESET during SHIFT at cnt=3 → next cycle busy=0 and resp_valid=0 (no result ever emitted); then req1 and req0 valid together → req0 granted first.
- Requester drop: req2 valid, then dropped before its turn while req3 is valid → req3 granted; req_ready[2] never asserted.
